// File: rtl/morph_pkg.sv
// Shared definitions for the binary morphology stages (erosion and dilation).
// Window bit order: bit 0 is the left column / top row, bit 2 is the right column / bottom row.
package morph_pkg;

  localparam int LINE_W_DEFAULT  = 800;
  localparam int FRAME_H_DEFAULT = 525;
  localparam int CNT_W_DEFAULT   = 20;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_e;

  localparam logic [2:0] MASK_KEEP_ALL  = 3'b111;
  localparam logic [2:0] MASK_LOW_EDGE  = 3'b110;
  localparam logic [2:0] MASK_HIGH_EDGE = 3'b011;

  // Bits of a window row or column that lie inside the frame.
  function automatic logic [2:0] edgeMask(input logic atLow, input logic atHigh);
    logic [2:0] m;
    m = MASK_KEEP_ALL;
    if (atLow)  m = m & MASK_LOW_EDGE;
    if (atHigh) m = m & MASK_HIGH_EDGE;
    return m;
  endfunction

endpackage

// File: rtl/shift_line.sv
// One-bit line delay: the output is the bit shifted in DEPTH enabled cycles earlier.
module shift_line
  import morph_pkg::*;
#(
  parameter int DEPTH = LINE_W_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic din_i,
  output logic dout_o
);

  logic [DEPTH-1:0] taps_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taps_q <= '0;
    end else if (en_i) begin
      taps_q <= {taps_q[DEPTH-2:0], din_i};
    end
  end

  assign dout_o = taps_q[DEPTH-1];

endmodule

// File: rtl/dilation_3x3.sv
// Binary 3x3 dilation of a raster 1-bit stream with frame-aware border masking.
// Output pixel k appears after the enabled edge accepting input pixel k+LINE_W+2.
module dilation_3x3
  import morph_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEFAULT,
  parameter int FRAME_H = FRAME_H_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic Pix_en,
  input  logic Sof,
  input  logic Data_in,
  output logic Data_out,
  output logic Out_valid,
  output logic Out_sof
);

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(LINE_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(FRAME_H - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(LINE_W + 1);

  logic             lineTap0, lineTap1;
  logic [2:0][2:0]  win_q;
  state_e           state_q, state_d;
  logic             fillAct_q, fillAct_d;
  logic [CNT_W-1:0] fillCnt_q, fillCnt_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             dataOut_q, outValid_q, outSof_q;
  logic             emit, emitSof, startNow, windowOr;
  logic [CNT_W-1:0] emitCol, emitRow;
  logic [2:0]       colMask, rowMask;

  shift_line #(.DEPTH(LINE_W)) uLine0 (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (Pix_en),
    .din_i (Data_in),
    .dout_o(lineTap0)
  );

  shift_line #(.DEPTH(LINE_W)) uLine1 (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (Pix_en),
    .din_i (lineTap0),
    .dout_o(lineTap1)
  );

  // Row 0 is the oldest line (top), row 2 the incoming line (bottom).
  always_ff @(posedge CLK) begin
    if (RST) begin
      win_q <= '0;
    end else if (Pix_en) begin
      win_q[0] <= {lineTap1, win_q[0][2:1]};
      win_q[1] <= {lineTap0, win_q[1][2:1]};
      win_q[2] <= {Data_in,  win_q[2][2:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      fillAct_q  <= 1'b0;
      fillCnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      dataOut_q  <= 1'b0;
      outValid_q <= 1'b0;
      outSof_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fillAct_q <= fillAct_d;
      fillCnt_q <= fillCnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      if (Pix_en) begin
        dataOut_q  <= emit & windowOr;
        outValid_q <= emit;
        outSof_q   <= emitSof;
      end
    end
  end

  // The fill counter runs alongside RUN so a new frame can take over seamlessly or early.
  always_comb begin
    state_d   = state_q;
    fillAct_d = fillAct_q;
    fillCnt_d = fillCnt_q;
    col_d     = col_q;
    row_d     = row_q;
    emit      = 1'b0;
    emitSof   = 1'b0;
    emitCol   = col_q;
    emitRow   = row_q;
    startNow  = fillAct_q && (fillCnt_q == FILL_LAST);
    if (Pix_en) begin
      if (Sof) begin
        fillAct_d = 1'b1;
        fillCnt_d = '0;
      end else if (startNow) begin
        fillAct_d = 1'b0;
      end else if (fillAct_q) begin
        fillCnt_d = fillCnt_q + CNT_W'(1);
      end

      if (startNow) begin
        emit    = 1'b1;
        emitSof = 1'b1;
        emitCol = '0;
        emitRow = '0;
        state_d = RUN;
      end else if (state_q == RUN) begin
        emit = 1'b1;
        if (col_q == COL_LAST && row_q == ROW_LAST) begin
          state_d = (Sof || fillAct_q) ? FILL : IDLE;
        end
      end else if (state_q == IDLE && Sof) begin
        state_d = FILL;
      end

      if (emit) begin
        if (emitCol == COL_LAST) begin
          col_d = '0;
          row_d = (emitRow == ROW_LAST) ? '0 : emitRow + CNT_W'(1);
        end else begin
          col_d = emitCol + CNT_W'(1);
          row_d = emitRow;
        end
      end
    end
  end

  always_comb begin
    colMask  = edgeMask(emitCol == '0, emitCol == COL_LAST);
    rowMask  = edgeMask(emitRow == '0, emitRow == ROW_LAST);
    windowOr = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (rowMask[r]) windowOr = windowOr | (|(win_q[r] & colMask));
    end
  end

  assign Data_out  = dataOut_q;
  assign Out_valid = outValid_q;
  assign Out_sof   = outSof_q;

endmodule

// File: tb/tb_dilation_3x3.sv
// Bench for dilation_3x3 on an 8x6 frame: directed single-pixel table plus random streams
// compared against a frame-level dilation model indexed by enabled-cycle count.
module tb_dilation_3x3;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int LAT  = W + 2;

  typedef struct {
    int pr;
    int pc;
    int rLo;
    int rHi;
    int cLo;
    int cHi;
  } dirVec_t;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic pixEn  = 1'b0;
  logic sof    = 1'b0;
  logic dataIn = 1'b0;
  logic dataOut, outValid, outSof;

  int checks = 0;
  int errors = 0;
  bit streamPix [4096];
  int sofList [$];
  int eIdx = 0;

  dilation_3x3 #(.LINE_W(W), .FRAME_H(H), .CNT_W(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .Pix_en   (pixEn),
    .Sof      (sof),
    .Data_in  (dataIn),
    .Data_out (dataOut),
    .Out_valid(outValid),
    .Out_sof  (outSof)
  );

  always #5 clk = ~clk;

  // A frame only starts if no later Sof restarts the fill before it completes.
  function automatic bit frameStarts(input int i);
    if (i == sofList.size() - 1) return 1'b1;
    return sofList[i+1] >= sofList[i] + LAT;
  endfunction

  // Expected outputs after the enabled edge with index e: latest started frame owns the output.
  function automatic void modelAt(input int e, output bit v, output bit s, output bit d);
    int best;
    best = -1;
    v = 1'b0;
    s = 1'b0;
    d = 1'b0;
    for (int i = 0; i < sofList.size(); i++) begin
      if (frameStarts(i) && sofList[i] + LAT <= e) best = i;
    end
    if (best >= 0) begin
      int base;
      int k;
      int r;
      int c;
      base = sofList[best];
      k = e - base - LAT;
      if (k < NPIX) begin
        r = k / W;
        c = k % W;
        v = 1'b1;
        s = (k == 0);
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
              d = d | streamPix[base + (r + dr) * W + (c + dc)];
            end
          end
        end
      end
    end
  endfunction

  function automatic void check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b (enable %0d, t=%0t)", name, got, want, eIdx, $time);
    end
  endfunction

  function automatic void checkInt(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endfunction

  task automatic checkOutput(input string tag);
    bit v, s, d;
    if (eIdx == 0) begin
      v = 1'b0;
      s = 1'b0;
      d = 1'b0;
    end else begin
      modelAt(eIdx - 1, v, s, d);
    end
    check1({tag, ".valid"}, outValid, v);
    check1({tag, ".sof"}, outSof, s);
    check1({tag, ".data"}, dataOut, d);
  endtask

  task automatic applyStimulus(input bit en, input bit sofIn, input bit pix, input string tag);
    @(negedge clk);
    rst    = 1'b0;
    pixEn  = en;
    sof    = sofIn;
    dataIn = pix;
    @(posedge clk);
    #1;
    if (en) begin
      streamPix[eIdx] = pix;
      if (sofIn) sofList.push_back(eIdx);
      eIdx++;
    end
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst    = 1'b1;
    pixEn  = 1'($urandom);
    sof    = 1'($urandom);
    dataIn = 1'($urandom);
    @(posedge clk);
    #1;
    eIdx = 0;
    sofList.delete();
    checkOutput(tag);
  endtask

  initial begin
    dirVec_t vecs [4];
    int validRun;
    int maxRun;
    int outCount;
    int onesSeen;
    int cyc;
    int k;
    bit en;
    bit want;
    int sofAt [$];

    vecs[0] = '{2, 3, 1, 3, 2, 4};
    vecs[1] = '{0, 0, 0, 1, 0, 1};
    vecs[2] = '{2, 7, 1, 3, 6, 7};
    vecs[3] = '{5, 0, 4, 5, 0, 1};

    doReset("reset");
    doReset("reset2");

    // Directed single-pixel frames: expected 1s form a clipped 3x3 rectangle.
    for (int vi = 0; vi < 4; vi++) begin
      doReset("dirReset");
      for (int e = 0; e < NPIX + LAT + 2; e++) begin
        applyStimulus(1'b1, e == 0, e == vecs[vi].pr * W + vecs[vi].pc, "dir");
        k = e - LAT;
        if (k >= 0 && k < NPIX) begin
          want = (k / W >= vecs[vi].rLo) && (k / W <= vecs[vi].rHi) &&
                 (k % W >= vecs[vi].cLo) && (k % W <= vecs[vi].cHi);
          check1("dirData", dataOut, want);
          check1("dirValid", outValid, 1'b1);
          check1("dirSof", outSof, k == 0);
        end else begin
          check1("dirIdle", outValid, 1'b0);
        end
      end
    end

    // Random frame under a random 50% enable duty; outputs must hold on idle cycles.
    doReset("dutyReset");
    cyc = 0;
    while (eIdx < NPIX + LAT + 4 && cyc < 2000) begin
      en = 1'($urandom);
      applyStimulus(en, eIdx == 0, (eIdx < NPIX) ? 1'($urandom) : 1'b0, "duty");
      cyc++;
    end

    // Two back-to-back frames must produce one unbroken run of valid pixels.
    doReset("b2bReset");
    validRun = 0;
    maxRun   = 0;
    outCount = 0;
    sofAt.delete();
    for (int e = 0; e < 2 * NPIX + LAT + 2; e++) begin
      applyStimulus(1'b1, e == 0 || e == NPIX, (e < 2 * NPIX) ? 1'($urandom) : 1'b0, "b2b");
      if (outValid) begin
        if (outSof) sofAt.push_back(outCount);
        outCount++;
        validRun++;
      end else begin
        if (validRun > maxRun) maxRun = validRun;
        validRun = 0;
      end
    end
    checkInt("b2bRun", maxRun, 2 * NPIX);
    checkInt("b2bSofCount", sofAt.size(), 2);
    checkInt("b2bSof0", (sofAt.size() > 0) ? sofAt[0] : -1, 0);
    checkInt("b2bSof1", (sofAt.size() > 1) ? sofAt[1] : -1, NPIX);

    // Sof restarting a fill, then an early Sof truncating a running frame.
    doReset("earlyReset");
    validRun = 0;
    maxRun   = 0;
    outCount = 0;
    for (int e = 0; e < 110; e++) begin
      applyStimulus(1'b1, e == 0 || e == 5 || e == 35 || e == 38,
                    (e < 100) ? 1'($urandom) : 1'b0, "early");
      if (outValid) begin
        if (outSof) outCount++;
        validRun++;
      end else begin
        if (validRun > maxRun) maxRun = validRun;
        validRun = 0;
      end
    end
    checkInt("earlySofCount", outCount, 2);
    checkInt("earlyRun", maxRun, (38 + LAT) - (5 + LAT) + NPIX);

    // Reset in the middle of a frame of ones, then an all-zero frame.
    doReset("midReset");
    for (int e = 0; e < 30; e++) applyStimulus(1'b1, e == 0, 1'b1, "midRun");
    doReset("midRunReset");
    for (int e = 0; e < 10; e++) applyStimulus(1'b1, 1'b0, 1'b0, "postIdle");
    onesSeen = 0;
    for (int e = 0; e < NPIX + LAT + 2; e++) begin
      applyStimulus(1'b1, e == 0, 1'b0, "zeroFrame");
      if (dataOut) onesSeen++;
    end
    checkInt("zeroFrameOnes", onesSeen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
